// File: rtl/axi_chan_checker.sv
// axi_chan_checker: compares AXI beats between an upstream port A and a downstream port B.
// Define AXI_CHAN_CHECKER_TIMEOUT_EN to enable per-channel stale-beat timeout detection.
package axi_chan_checker_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;
  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;
  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_chan_checker_chan #(
  parameter int unsigned Width         = 1,
  parameter int unsigned Depth         = 4,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             cmp_i,
  input  logic [Width-1:0] push_data_i,
  input  logic [Width-1:0] cmp_data_i,
  output logic [3:0]       flags_o,
  output logic [3:0]       events_o,
  output logic             busy_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] PtrMax = PtrW'(Depth - 1);
  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0] flags_q, flags_d;
  logic push, cmp, empty, full, pop, store, tmo_hit;
  assign push = push_i & ~clear_i;
  assign cmp = cmp_i & ~clear_i;
  assign empty = cnt_q == '0;
  assign full = cnt_q == CntW'(Depth);
  assign pop = cmp & ~empty;
  // An empty buffer with a same-cycle compare bypasses storage entirely
  assign store = push & ~(empty & cmp) & (~full | pop);
  assign events_o = {tmo_hit, cmp & ~push & empty, push & ~pop & full,
                     cmp & (empty ? push & (push_data_i != cmp_data_i) : mem_q[rptr_q] != cmp_data_i)};
  assign flags_o = flags_q;
  assign busy_o = ~empty;
  always_comb begin
    mem_d = mem_q;
    if (store) mem_d[wptr_q] = push_data_i;
    wptr_d = clear_i ? '0 : store ? (wptr_q == PtrMax ? '0 : wptr_q + 1'b1) : wptr_q;
    rptr_d = clear_i ? '0 : pop ? (rptr_q == PtrMax ? '0 : rptr_q + 1'b1) : rptr_q;
    cnt_d = clear_i ? '0 : cnt_q + CntW'(store) - CntW'(pop);
    flags_d = clear_i ? '0 : flags_q | events_o;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      flags_q <= '0;
    end else begin
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q <= cnt_d;
      flags_q <= flags_d;
    end
  end
`ifdef AXI_CHAN_CHECKER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic tmo_rst;
  assign tmo_rst = clear_i | pop | empty;
  // Fires once on reaching the limit, then the counter parks until the next pop
  assign tmo_hit = ~tmo_rst & (tmo_q == TmoW'(TimeoutCycles - 1));
  assign tmo_d = tmo_rst ? '0 : tmo_q == TmoW'(TimeoutCycles) ? tmo_q : tmo_q + 1'b1;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tmo_q <= '0;
    else tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif
endmodule

module axi_chan_checker #(
  parameter int unsigned FifoDepth     = 4,
  parameter bit          IgnoreId      = 1'b0,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = 1024,
  parameter type aw_chan_t = axi_chan_checker_pkg::aw_chan_t,
  parameter type w_chan_t  = axi_chan_checker_pkg::w_chan_t,
  parameter type b_chan_t  = axi_chan_checker_pkg::b_chan_t,
  parameter type ar_chan_t = axi_chan_checker_pkg::ar_chan_t,
  parameter type r_chan_t  = axi_chan_checker_pkg::r_chan_t,
  parameter type req_t     = axi_chan_checker_pkg::req_t,
  parameter type resp_t    = axi_chan_checker_pkg::resp_t
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  req_t                axi_a_req_i,
  input  resp_t               axi_a_resp_i,
  input  req_t                axi_b_req_i,
  input  resp_t               axi_b_resp_i,
  output logic [4:0]          mismatch_o,
  output logic [4:0]          overflow_o,
  output logic [4:0]          underflow_o,
  output logic [4:0]          timeout_o,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic                busy_o
);
  localparam int unsigned SumW = CntWidth + 6;
  aw_chan_t aw_a, aw_b;
  w_chan_t w_a, w_b;
  b_chan_t b_a, b_b;
  ar_chan_t ar_a, ar_b;
  r_chan_t r_a, r_b;
  logic [4:0][3:0] flg, ev;
  logic [4:0] busy;
  logic [SumW-1:0] tot;
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
  always_comb begin
    aw_a = axi_a_req_i.aw;
    aw_b = axi_b_req_i.aw;
    w_a = axi_a_req_i.w;
    w_b = axi_b_req_i.w;
    b_a = axi_a_resp_i.b;
    b_b = axi_b_resp_i.b;
    ar_a = axi_a_req_i.ar;
    ar_b = axi_b_req_i.ar;
    r_a = axi_a_resp_i.r;
    r_b = axi_b_resp_i.r;
    if (IgnoreId) begin
      aw_a.id = '0;
      aw_b.id = '0;
      b_a.id = '0;
      b_b.id = '0;
      ar_a.id = '0;
      ar_b.id = '0;
      r_a.id = '0;
      r_b.id = '0;
    end
  end
  axi_chan_checker_chan #(.Width($bits(aw_chan_t)), .Depth(FifoDepth), .TimeoutCycles(TimeoutCycles)) u_aw (
    .clk_i, .rst_i, .clear_i,
    .push_i(axi_a_req_i.aw_valid & axi_a_resp_i.aw_ready), .push_data_i(aw_a),
    .cmp_i(axi_b_req_i.aw_valid & axi_b_resp_i.aw_ready), .cmp_data_i(aw_b),
    .flags_o(flg[0]), .events_o(ev[0]), .busy_o(busy[0]));
  axi_chan_checker_chan #(.Width($bits(w_chan_t)), .Depth(FifoDepth), .TimeoutCycles(TimeoutCycles)) u_w (
    .clk_i, .rst_i, .clear_i,
    .push_i(axi_a_req_i.w_valid & axi_a_resp_i.w_ready), .push_data_i(w_a),
    .cmp_i(axi_b_req_i.w_valid & axi_b_resp_i.w_ready), .cmp_data_i(w_b),
    .flags_o(flg[1]), .events_o(ev[1]), .busy_o(busy[1]));
  axi_chan_checker_chan #(.Width($bits(b_chan_t)), .Depth(FifoDepth), .TimeoutCycles(TimeoutCycles)) u_b (
    .clk_i, .rst_i, .clear_i,
    .push_i(axi_b_resp_i.b_valid & axi_b_req_i.b_ready), .push_data_i(b_b),
    .cmp_i(axi_a_resp_i.b_valid & axi_a_req_i.b_ready), .cmp_data_i(b_a),
    .flags_o(flg[2]), .events_o(ev[2]), .busy_o(busy[2]));
  axi_chan_checker_chan #(.Width($bits(ar_chan_t)), .Depth(FifoDepth), .TimeoutCycles(TimeoutCycles)) u_ar (
    .clk_i, .rst_i, .clear_i,
    .push_i(axi_a_req_i.ar_valid & axi_a_resp_i.ar_ready), .push_data_i(ar_a),
    .cmp_i(axi_b_req_i.ar_valid & axi_b_resp_i.ar_ready), .cmp_data_i(ar_b),
    .flags_o(flg[3]), .events_o(ev[3]), .busy_o(busy[3]));
  axi_chan_checker_chan #(.Width($bits(r_chan_t)), .Depth(FifoDepth), .TimeoutCycles(TimeoutCycles)) u_r (
    .clk_i, .rst_i, .clear_i,
    .push_i(axi_b_resp_i.r_valid & axi_b_req_i.r_ready), .push_data_i(r_b),
    .cmp_i(axi_a_resp_i.r_valid & axi_a_req_i.r_ready), .cmp_data_i(r_a),
    .flags_o(flg[4]), .events_o(ev[4]), .busy_o(busy[4]));
  for (genvar i = 0; i < 5; i++) begin : g_flags
    assign mismatch_o[i] = flg[i][0];
    assign overflow_o[i] = flg[i][1];
    assign underflow_o[i] = flg[i][2];
    assign timeout_o[i] = flg[i][3];
  end
  assign busy_o = |busy;
  assign err_cnt_o = err_cnt_q;
  // Widened sum so the saturation check sees carries beyond CntWidth
  assign tot = SumW'(err_cnt_q) + SumW'($countones(ev));
  assign err_cnt_d = clear_i ? '0 : |tot[SumW-1:CntWidth] ? '1 : tot[CntWidth-1:0];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
endmodule
